seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised dynamic 7-segment scanner: owns dwell prescaler, rotating digit
//  select, per-digit hex decode, decimal point, blanking and anti-ghost gap.
//  Sits between the counters/datapath producing nibble values and the board's
//  shared segment bus plus digit-select lines. Frame-coherent: new data only
//  takes effect at a frame boundary, so no digit tearing.
// PARAMETERS
//  NUM_DIG    8       digits scanned (2..16)
//  DWELL_CYC  50000   sys_clk cycles per digit (>= BLANK_CYC+2)
//  BLANK_CYC  500     cycles at start of each dwell with all selects inactive
//  SEG_ACT_LOW 1      1: seg/dp driven low = lit; 0: inverted
//  SEL_ACT_LOW 1      1: selected digit driven low (one-cold); 0: one-hot
// PORTS
//  sys_clk    in   1           system clock, 50 MHz
//  sys_rst    in   1           synchronous reset, active-high
//  en         in   1           scan enable; 0 = display dark, counters hold
//  load       in   1           1-cycle strobe: capture data/dp/blank into shadow
//  data       in   4*NUM_DIG   nibble per digit, digit k = data[4k+3:4k]
//  dp         in   NUM_DIG     decimal point request per digit
//  blank      in   NUM_DIG     1 = digit k dark (sel still rotates past it)
//  sel        out  NUM_DIG     digit select, polarity per SEL_ACT_LOW
//  seg        out  7           seg[6]=a .. seg[0]=g, polarity per SEG_ACT_LOW
//  seg_dp     out  1           decimal point segment
//  frame_tick out  1           1-cycle pulse when frame regs reload (digit 0 start)
// BEHAVIOUR
//  Reset (sys_rst=1 at edge): dwell cnt=0, idx=0, shadow/frame regs=0,
//   sel all inactive, seg/seg_dp all off, frame_tick=0. Reset wins over all.
//  Shadow: on load=1, shadow <= {data,dp,blank} next edge. load during reset ignored.
//  Dwell cnt: when en=1 counts 0..DWELL_CYC-1 and wraps; end_dw = (cnt==DWELL_CYC-1).
//   On end_dw: idx <= (idx==NUM_DIG-1) ? 0 : idx+1.
//  Frame: when end_dw and idx==NUM_DIG-1, frame regs <= shadow and frame_tick=1
//   on the following cycle (same cycle idx becomes 0). A load in that same end_dw
//   cycle is NOT included (frame takes old shadow); it appears next frame.
//  Outputs registered, 1-cycle latency from cnt/idx:
//   cnt < BLANK_CYC -> sel all inactive, seg/seg_dp off (anti-ghost gap).
//   else sel active only at bit idx; if frame blank[idx]=1 seg/seg_dp off,
//   else seg=decode(frame nibble idx), seg_dp=frame dp[idx].
//  Decode, active-low a..g (SEG_ACT_LOW=1; invert all for 0):
//   0 0000001 1 1001111 2 0010010 3 0000110 4 1001100 5 0100100 6 0100000
//   7 0001111 8 0000000 9 0000100 A 0001000 b 1100000 C 0110001 d 1000010
//   E 0110000 F 0111000
//  en=0: cnt and idx hold; next cycle sel inactive, seg/seg_dp off, no
//   frame_tick. en 0->1 resumes at held cnt/idx (no skipped digit).
//  Mid-dwell reset: outputs dark the cycle after reset edge; scan restarts at digit 0.
//  Exactly one sel active at any time outside gap; never two (check every cycle).
// TESTING (bench: NUM_DIG=4, DWELL_CYC=8, BLANK_CYC=2, both polarities =1)
//  T1 reset, load data=16'h3210, en=1 -> after first frame_tick sel cycles
//   1110,1101,1011,0111, 6 lit cycles each, seg 0000001,1001111,0010010,0000110.
//  T2 gap: every dwell's first 2 output cycles sel=1111, seg=1111111; one-cold elsewhere.
//  T3 frame coherence: load 16'hFEDC while idx=1 -> digits 2,3 still show 2,3;
//   next frame shows C,d,E,F (0110001,1000010,0110000,0111000).
//  T4 blank=4'b0100, dp=4'b0001 -> digit 2 seg=1111111 with sel active; digit 0 seg_dp=0.
//  T5 en=0 for 20 cycles mid-dwell of digit 1 -> outputs dark, no frame_tick;
//   en=1 -> digit 1 resumes with remaining dwell count.
//  T6 sys_rst mid-scan, also with load high -> dark next cycle, shadow=0, restart at digit 0.

Source files
------------

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_if
//  Brief    : Data/display bundle between the nibble producer and seg_scan_mux.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_if #(
    parameter int NUM_DIG = 8
) ();
    logic                   en;
    logic                   load;
    logic [4*NUM_DIG-1:0]   data;
    logic [NUM_DIG-1:0]     dp;
    logic [NUM_DIG-1:0]     blank;
    logic [NUM_DIG-1:0]     sel;
    logic [6:0]             seg;
    logic                   seg_dp;
    logic                   frame_tick;

    modport master (
        output en, load, data, dp, blank,
        input  sel, seg, seg_dp, frame_tick
    );

    modport slave (
        input  en, load, data, dp, blank,
        output sel, seg, seg_dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Brief    : Frame-coherent multiplexed 7-segment scanner with hex decode,
//             decimal point, per-digit blanking and an anti-ghost select gap.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_DIG     = 8,
    parameter int DWELL_CYC   = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  wire logic   sys_clk,
    input  wire logic   sys_rst,
    seg_scan_if.slave   bus
);
    localparam int CW = $clog2(DWELL_CYC);
    localparam int IW = $clog2(NUM_DIG);

    localparam logic [CW-1:0]      c_cnt_last = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0]      c_blank    = CW'(BLANK_CYC);
    localparam logic [IW-1:0]      c_idx_last = IW'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] c_one      = NUM_DIG'(1);
    localparam logic [NUM_DIG-1:0] c_sel_off  = SEL_ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [6:0]         c_seg_off  = SEG_ACT_LOW ? 7'h7f : 7'h00;
    localparam logic               c_dp_off   = SEG_ACT_LOW;

    // Decode table is stored active-low (a..g), polarity applied afterwards.
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0: v = 7'b0000001;
            4'h1: v = 7'b1001111;
            4'h2: v = 7'b0010010;
            4'h3: v = 7'b0000110;
            4'h4: v = 7'b1001100;
            4'h5: v = 7'b0100100;
            4'h6: v = 7'b0100000;
            4'h7: v = 7'b0001111;
            4'h8: v = 7'b0000000;
            4'h9: v = 7'b0000100;
            4'hA: v = 7'b0001000;
            4'hB: v = 7'b1100000;
            4'hC: v = 7'b0110001;
            4'hD: v = 7'b1000010;
            4'hE: v = 7'b0110000;
            default: v = 7'b0111000;
        endcase
        return v;
    endfunction

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*NUM_DIG-1:0]   r_sh_data;
    logic [NUM_DIG-1:0]     r_sh_dp;
    logic [NUM_DIG-1:0]     r_sh_blank;
    logic [4*NUM_DIG-1:0]   r_fr_data;
    logic [NUM_DIG-1:0]     r_fr_dp;
    logic [NUM_DIG-1:0]     r_fr_blank;
    logic [NUM_DIG-1:0]     r_sel;
    logic [6:0]             r_seg;
    logic                   r_seg_dp;
    logic                   r_frame_tick;

    logic                   w_end_dw;
    logic                   w_last_dig;
    logic                   w_gap;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg_lit;
    logic                   w_dp_lit;
    logic [NUM_DIG-1:0]     w_sel_lit;

    assign w_end_dw   = (r_cnt == c_cnt_last);
    assign w_last_dig = (r_idx == c_idx_last);
    assign w_gap      = (r_cnt < c_blank);
    assign w_nib      = r_fr_data[{r_idx, 2'b00} +: 4];
    assign w_seg_lit  = SEG_ACT_LOW ? f_decode(w_nib) : ~f_decode(w_nib);
    assign w_dp_lit   = SEG_ACT_LOW ? ~r_fr_dp[r_idx] : r_fr_dp[r_idx];
    assign w_sel_lit  = SEL_ACT_LOW ? ~(c_one << r_idx) : (c_one << r_idx);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_fr_data    <= '0;
            r_fr_dp      <= '0;
            r_fr_blank   <= '0;
            r_sel        <= c_sel_off;
            r_seg        <= c_seg_off;
            r_seg_dp     <= c_dp_off;
            r_frame_tick <= 1'b0;
        end else begin
            if (bus.load) begin
                r_sh_data  <= bus.data;
                r_sh_dp    <= bus.dp;
                r_sh_blank <= bus.blank;
            end

            r_frame_tick <= 1'b0;
            if (bus.en) begin
                if (w_end_dw) begin
                    r_cnt <= '0;
                    if (w_last_dig) begin
                        // Frame regs take the pre-edge shadow, so a coincident load waits a frame.
                        r_idx        <= '0;
                        r_fr_data    <= r_sh_data;
                        r_fr_dp      <= r_sh_dp;
                        r_fr_blank   <= r_sh_blank;
                        r_frame_tick <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (!bus.en || w_gap) begin
                r_sel    <= c_sel_off;
                r_seg    <= c_seg_off;
                r_seg_dp <= c_dp_off;
            end else begin
                r_sel <= w_sel_lit;
                if (r_fr_blank[r_idx]) begin
                    r_seg    <= c_seg_off;
                    r_seg_dp <= c_dp_off;
                end else begin
                    r_seg    <= w_seg_lit;
                    r_seg_dp <= w_dp_lit;
                end
            end
        end
    end

    assign bus.sel        = r_sel;
    assign bus.seg        = r_seg;
    assign bus.seg_dp     = r_seg_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Brief    : Self-checking bench for seg_scan_mux against a cycle-position model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BL = 2;
    localparam int FR = ND * DW;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    seg_scan_if #(.NUM_DIG(ND)) bus ();

    seg_scan_mux #(
        .NUM_DIG(ND), .DWELL_CYC(DW), .BLANK_CYC(BL),
        .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: scan position within a frame in enabled cycles, plus shadow/frame contents.
    int         p;
    logic [15:0] sh_data, fr_data;
    logic [3:0]  sh_dp, sh_blank, fr_dp, fr_blank;
    logic [6:0]  dec_tab [16];
    logic [3:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int dig;
        int phase;
        @(posedge sys_clk);
        if (sys_rst) begin
            e_sel = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
            p = 0; sh_data = '0; sh_dp = '0; sh_blank = '0;
            fr_data = '0; fr_dp = '0; fr_blank = '0;
        end else begin
            phase = p % DW;
            dig   = p / DW;
            if (!bus.en || phase < BL) begin
                e_sel = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_sel = ~(4'(1) << dig);
                if (fr_blank[dig]) begin
                    e_seg = 7'h7F; e_dp = 1'b1;
                end else begin
                    e_seg = dec_tab[fr_data[dig*4 +: 4]];
                    e_dp  = ~fr_dp[dig];
                end
            end
            e_tick = bus.en && (p == FR - 1);
            if (e_tick) begin
                fr_data = sh_data; fr_dp = sh_dp; fr_blank = sh_blank;
            end
            if (bus.load) begin
                sh_data = bus.data; sh_dp = bus.dp; sh_blank = bus.blank;
            end
            if (bus.en) p = (p + 1) % FR;
        end
        #1;
        chk("sel", 32'(bus.sel), 32'(e_sel));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("seg_dp", 32'(bus.seg_dp), 32'(e_dp));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
        chk("one_cold", 32'($countones(~bus.sel) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FR && p != target; i++) step();
        chk("reach_pos", 32'(p), 32'(target));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bk);
        bus.data = d; bus.dp = dpv; bus.blank = bk; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        bus.en = 1'b0; bus.load = 1'b0; bus.data = '0; bus.dp = '0; bus.blank = '0;
        p = 0;

        // Reset state
        sys_rst = 1'b1;
        run(3);
        sys_rst = 1'b0;

        // Basic scan of 3,2,1,0 with gaps
        do_load(16'h3210, 4'h0, 4'h0);
        bus.en = 1'b1;
        run(3 * FR);

        // Load mid-frame while digit 1 is shown; takes effect next frame
        run_to(12);
        do_load(16'hFEDC, 4'h0, 4'h0);
        run(2 * FR);

        // Blanking and decimal point
        do_load(16'h9876, 4'b0001, 4'b0100);
        run(2 * FR);

        // Enable pause mid-dwell of digit 1
        run_to(12);
        bus.en = 1'b0;
        run(20);
        bus.en = 1'b1;
        run(FR + 8);

        // Pause straddling the frame boundary
        run_to(FR - 1);
        bus.en = 1'b0;
        run(5);
        bus.en = 1'b1;
        run(FR);

        // Load coincident with the frame reload edge
        run_to(FR - 1);
        do_load(16'h5A5A, 4'b1010, 4'h0);
        run(2 * FR);

        // Reset mid-scan with load held high
        run_to(19);
        bus.data = 16'hABCD; bus.dp = 4'hF; bus.blank = 4'h0; bus.load = 1'b1;
        sys_rst = 1'b1;
        run(2);
        sys_rst = 1'b0; bus.load = 1'b0;
        run(2 * FR);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.en    = ($urandom % 10) != 0;
            bus.load  = ($urandom % 12) == 0;
            bus.data  = 16'($urandom);
            bus.dp    = 4'($urandom);
            bus.blank = 4'($urandom) & 4'($urandom);
            sys_rst   = ($urandom % 250) == 0;
            step();
        end
        sys_rst = 1'b0; bus.load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end
endmodule
`default_nettype wire
